// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the LSU memory initiator.
// Holds the access size and FSM state encodings plus the timeout default.
package lsu_pkg;

    localparam int LSU_TIMEOUT_DEF = 16;
    localparam int LSU_XLEN        = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_e;

    // Size 3 is illegal; halves need an even address, words a 4-aligned one.
    function automatic logic bad_access(input logic [1:0] size,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU initiator.
// Ports: lane/size/is_unsigned select the access; wdata/rdata are the raw
// store and read words; load_data is the extracted, extended load result;
// store_data is the replicated store word; strobe the byte enables.
// With RMW_EN defined, old_word/merged add the read-modify-write merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
`ifdef RMW_EN
    input  logic [31:0] old_word,
    output logic [31:0] merged,
`endif
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  strobe
);

    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{lane, 3'b000} +: 8];
    assign h = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = '0;
        store_data = '0;
        strobe     = '0;
        case (size)
            SZ_B: begin
                load_data  = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
                store_data = {4{wdata[7:0]}};
                strobe     = 4'b0001 << lane;
            end
            SZ_H: begin
                load_data  = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
                store_data = {2{wdata[15:0]}};
                strobe     = 4'b0011 << lane;
            end
            SZ_W: begin
                load_data  = rdata;
                store_data = wdata;
                strobe     = 4'hF;
            end
            default: ;
        endcase
    end

`ifdef RMW_EN
    logic [31:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
    end

    // Strobed lanes take the new data, the rest keep the word read back.
    assign merged = (store_data & mask) | (old_word & ~mask);
`endif

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: turns single LSU load/store ops into word-aligned
// memory requests with strobes and returns aligned, extended load data.
// Ports: req_* operation handshake in; done_* one-cycle completion out;
// mem_r_v/mem_w_v/mem_adr/mem_data/mem_strobe request to the responder;
// mem_resp/mem_resp_valid/mem_resp_error response back.
// Optional: RMW_EN makes sub-word stores read-modify-write.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEF,
    parameter int XLEN    = LSU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    output logic            done_valid,
    output logic [XLEN-1:0] done_rdata,
    output logic            done_error,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [31:0]     mem_adr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [XLEN-1:0] mem_resp,
    input  logic            mem_resp_valid,
    input  logic            mem_resp_error
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            run_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            take;
    logic            bad_in;

    logic [31:0]     load_data;
    logic [31:0]     store_data;
    logic [3:0]      strobe;

`ifdef RMW_EN
    logic [31:0]     rmw_q, rmw_d;
    logic [31:0]     merged;
    localparam state_e SUB_ST = RMW_RD;
`else
    localparam state_e SUB_ST = WR;
`endif

    lsu_lane_align u_align (
        .lane        (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (mem_resp),
`ifdef RMW_EN
        .old_word    (rmw_q),
        .merged      (merged),
`endif
        .load_data   (load_data),
        .store_data  (store_data),
        .strobe      (strobe)
    );

    assign bad_in = bad_access(req_size, req_addr[1:0]);

    // run_q holds req_ready low until the first edge after reset release.
    assign req_ready = run_q && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        take    = 1'b0;
`ifdef RMW_EN
        rmw_d   = rmw_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    take    = 1'b1;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    unique case (1'b1)
                        bad_in: begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                        !bad_in && !req_we:
                            state_d = RD;
                        !bad_in && req_we && req_size == SZ_W:
                            state_d = WR;
                        !bad_in && req_we && req_size != SZ_W:
                            state_d = SUB_ST;
                        default: ;
                    endcase
                end
            end
            RD: begin
                if (mem_resp_valid) begin
                    state_d = DONE;
                    if (mem_resp_error) err_d = 1'b1;
                    else rdata_d = load_data;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                state_d = DONE;
                err_d   = mem_resp_error;
            end
`ifdef RMW_EN
            RMW_RD: begin
                if (mem_resp_valid) begin
                    if (mem_resp_error) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = RMW_WR;
                        rmw_d   = mem_resp;
                    end
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RMW_WR: begin
                state_d = DONE;
                err_d   = mem_resp_error;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef RMW_EN
            rmw_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef RMW_EN
            rmw_q   <= rmw_d;
`endif
            if (take) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
            end
        end
    end

    // Memory side depends only on registered state and request fields.
    always_comb begin
        mem_r_v    = 1'b0;
        mem_w_v    = 1'b0;
        mem_data   = '0;
        mem_strobe = '0;
        mem_adr    = {addr_q[31:2], 2'b00};
        case (state_q)
            RD: begin
                mem_r_v    = 1'b1;
                mem_strobe = strobe;
            end
            WR: begin
                mem_w_v    = we_q;
                mem_data   = store_data;
                mem_strobe = strobe;
            end
`ifdef RMW_EN
            RMW_RD: begin
                mem_r_v    = 1'b1;
                mem_strobe = 4'hF;
            end
            RMW_WR: begin
                mem_w_v    = 1'b1;
                mem_data   = merged;
                mem_strobe = 4'hF;
            end
`endif
            default: ;
        endcase
    end

    assign done_valid = (state_q == DONE);
    assign done_rdata = done_valid ? rdata_q : '0;
    assign done_error = done_valid && err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed table-driven bench for lsu_mem_initiator
// with a behavioural responder and hand-written reset/timeout sequences.
module tb_lsu_mem_initiator;

    localparam int TO = 8;
`ifdef RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        done_error;
    logic        mem_r_v;
    logic        mem_w_v;
    logic [31:0] mem_adr;
    logic [31:0] mem_data;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_resp;
    logic        mem_resp_valid;
    logic        mem_resp_error;

    lsu_mem_initiator #(.TIMEOUT(TO), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .done_valid     (done_valid),
        .done_rdata     (done_rdata),
        .done_error     (done_error),
        .mem_r_v        (mem_r_v),
        .mem_w_v        (mem_w_v),
        .mem_adr        (mem_adr),
        .mem_data       (mem_data),
        .mem_strobe     (mem_strobe),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_error (mem_resp_error)
    );

    always #5 clk = ~clk;

    // responder and monitors
    logic [31:0] mem_word = '0;
    logic        resp_en  = 1'b1;
    logic        resp_err = 1'b0;
    int          rd_cyc = 0, wr_cyc = 0, both_hi = 0, done_cnt = 0;
    logic [31:0] last_wdata = '0, last_adr = '0;
    logic [3:0]  last_strobe = '0;

    initial begin
        mem_resp       = '0;
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
    end

    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        mem_resp_error = 1'b0;
        mem_resp       = '0;
        if (mem_r_v && mem_w_v) both_hi++;
        if (mem_r_v) begin
            rd_cyc++;
            if (resp_en) begin
                mem_resp_valid = 1'b1;
                mem_resp       = mem_word;
                mem_resp_error = resp_err;
            end
        end
        if (mem_w_v) begin
            wr_cyc++;
            last_wdata     = mem_data;
            last_strobe    = mem_strobe;
            last_adr       = mem_adr;
            mem_resp_error = resp_err;
        end
        if (done_valid) done_cnt++;
    end

    int checks = 0, failures = 0, exp_dones = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] word;
        logic        en;
        logic        err;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_rd;
        int          e_wr;
        logic [31:0] e_wdata;
        logic [3:0]  e_stb;
    } vec_t;

    function automatic vec_t mk(
        input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [1:0] size, input logic uns, input logic [31:0] word,
        input logic en, input logic err, input logic [31:0] e_rdata,
        input logic e_err, input int e_lat, input int e_rd, input int e_wr,
        input logic [31:0] e_wdata, input logic [3:0] e_stb);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.uns = uns; v.word = word; v.en = en; v.err = err;
        v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_wdata = e_wdata; v.e_stb = e_stb;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!req_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk({name, "_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input vec_t v, input string name);
        int lat, rd0, wr0;
        logic [31:0] got_d;
        logic        got_e;
        mem_word = v.word;
        resp_en  = v.en;
        resp_err = v.err;
        wait_ready(name);
        rd0 = rd_cyc;
        wr0 = wr_cyc;
        req_we       = v.we;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        exp_dones++;
        req_valid    = 1'b0;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = 32'h5A5A_5A5A;
        req_size     = 2'd3;
        req_we       = ~v.we;
        req_unsigned = ~v.uns;
        lat = 1;
        while (!done_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got_d = done_rdata;
        got_e = done_error;
        chk({name, "_lat"}, 32'(lat), 32'(v.e_lat));
        chk({name, "_rdata"}, got_d, v.e_rdata);
        chk({name, "_err"}, {31'b0, got_e}, {31'b0, v.e_err});
        chk({name, "_rdcyc"}, 32'(rd_cyc - rd0), 32'(v.e_rd));
        chk({name, "_wrcyc"}, 32'(wr_cyc - wr0), 32'(v.e_wr));
        if (v.e_wr > 0) begin
            chk({name, "_wdata"}, last_wdata, v.e_wdata);
            chk({name, "_strobe"}, {28'b0, last_strobe}, {28'b0, v.e_stb});
            chk({name, "_adr"}, last_adr, {v.addr[31:2], 2'b00});
        end
        @(posedge clk); #1;
        chk({name, "_ready_next"}, {31'b0, req_ready}, 32'd1);
    endtask

    vec_t vt[$];

    initial begin
        // byte/half loads from 0x80FF1234, lanes and extension
        vt.push_back(mk(0, 32'h103, 0, 2'd0, 0, 32'h80FF1234, 1, 0,
                        32'hFFFFFF80, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'h103, 0, 2'd0, 1, 32'h80FF1234, 1, 0,
                        32'h00000080, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'h102, 0, 2'd1, 0, 32'h80FF1234, 1, 0,
                        32'hFFFF80FF, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'h100, 0, 2'd1, 1, 32'h80FF1234, 1, 0,
                        32'h00001234, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'h101, 0, 2'd0, 0, 32'h80FF1234, 1, 0,
                        32'h00000012, 0, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 32'h200, 0, 2'd2, 0, 32'h80FF1234, 1, 0,
                        32'h80FF1234, 0, 2, 1, 0, 0, 0));
        // word store
        vt.push_back(mk(1, 32'h204, 32'hDEADBEEF, 2'd2, 0, 32'h0, 1, 0,
                        32'h0, 0, 2, 0, 1, 32'hDEADBEEF, 4'hF));
        // sub-word stores
        vt.push_back(RMW ?
            mk(1, 32'h205, 32'h000000AB, 2'd0, 0, 32'h11223344, 1, 0,
               32'h0, 0, 3, 1, 1, 32'h1122AB44, 4'hF) :
            mk(1, 32'h205, 32'h000000AB, 2'd0, 0, 32'h11223344, 1, 0,
               32'h0, 0, 2, 0, 1, 32'hABABABAB, 4'b0010));
        vt.push_back(RMW ?
            mk(1, 32'h206, 32'h0000BEEF, 2'd1, 0, 32'h11223344, 1, 0,
               32'h0, 0, 3, 1, 1, 32'hBEEF3344, 4'hF) :
            mk(1, 32'h206, 32'h0000BEEF, 2'd1, 0, 32'h11223344, 1, 0,
               32'h0, 0, 2, 0, 1, 32'hBEEFBEEF, 4'b1100));
        // misaligned and illegal: no memory access
        vt.push_back(mk(0, 32'h301, 0, 2'd2, 0, 32'h12345678, 1, 0,
                        32'h0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 32'h303, 32'h1234, 2'd1, 0, 32'h0, 1, 0,
                        32'h0, 1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 32'h300, 0, 2'd3, 0, 32'h12345678, 1, 0,
                        32'h0, 1, 1, 0, 0, 0, 0));
        // responder errors, then a normal op
        vt.push_back(mk(0, 32'hF000, 0, 2'd2, 0, 32'h55AA55AA, 1, 1,
                        32'h0, 1, 2, 1, 0, 0, 0));
        vt.push_back(mk(1, 32'hF004, 32'h01020304, 2'd2, 0, 32'h0, 1, 1,
                        32'h0, 1, 2, 0, 1, 32'h01020304, 4'hF));
        vt.push_back(mk(0, 32'h400, 0, 2'd0, 0, 32'h0000007F, 1, 0,
                        32'h0000007F, 0, 2, 1, 0, 0, 0));
        // RMW read error skips the write
        vt.push_back(RMW ?
            mk(1, 32'hF009, 32'hCD, 2'd0, 0, 32'h0, 1, 1,
               32'h0, 1, 2, 1, 0, 0, 0) :
            mk(1, 32'hF009, 32'hCD, 2'd0, 0, 32'h0, 1, 1,
               32'h0, 1, 2, 0, 1, 32'hCDCDCDCD, 4'b0010));
        // timeout: responder silent
        vt.push_back(mk(0, 32'h500, 0, 2'd2, 0, 32'h0, 0, 0,
                        32'h0, 1, TO + 1, TO, 0, 0, 0));

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_size     = '0;
        req_unsigned = 1'b0;

        #12;
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_done", {31'b0, done_valid}, 32'd0);
        chk("rst_rv", {31'b0, mem_r_v}, 32'd0);
        chk("rst_wv", {31'b0, mem_w_v}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        chk("rst_adr", mem_adr, 32'd0);
        chk("rst_rdata", done_rdata, 32'd0);
        #1 rst_n = 1'b1;
        #1 chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("ready_first_cycle", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i], $sformatf("v%0d", i));
        end

        // reset while a read is outstanding
        begin
            int d0;
            resp_en  = 1'b0;
            resp_err = 1'b0;
            wait_ready("mid_rst");
            req_we    = 1'b0;
            req_addr  = 32'h600;
            req_size  = 2'd2;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("mid_rst_rv_on", {31'b0, mem_r_v}, 32'd1);
            d0 = done_cnt;
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst_rv_off", {31'b0, mem_r_v}, 32'd0);
            chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        end
        run_op(mk(0, 32'h700, 0, 2'd2, 0, 32'hCAFEF00D, 1, 0,
                  32'hCAFEF00D, 0, 2, 1, 0, 0, 0), "post_rst");

        chk("never_both", 32'(both_hi), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'(exp_dones));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=hang exp=finish");
        $fatal(1);
    end

endmodule
